rom_dl_sched: RTL and testbench

Download scheduler between the HPS ioctl stream and the dual-port SDRAM controller, running in the `clk_mem` domain. It turns ioctl write strobes into toggle-handshake requests on SDRAM port1 and port2. Every byte goes to port1, as a linear image. Sprite-region bytes also go to port2, remapped into 32-bit sprite words. A small FIFO and an `ioctl_wait` back-pressure output replace the earlier fire-and-forget toggling, so no write is lost when the SDRAM is slow to acknowledge.

---
 rtl/rom_dl_pkg.sv | 18 +
 rtl/rom_dl_sched_if.sv | 35 +++
 rtl/rom_dl_fifo.sv | 59 +++++
 rtl/rom_dl_sched.sv | 154 +++++++++++++++
 tb/tb_rom_dl_sched.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_dl_pkg.sv
// Shared types and defaults for the ROM download scheduler.
package rom_dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } dl_state_e;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

  localparam logic [24:0] SP_BASE_DEF = 25'h10000;
  localparam logic [24:0] SP_END_DEF  = 25'h1C000;

endpackage

// File: rtl/rom_dl_sched_if.sv
// ioctl download stream plus the two SDRAM toggle-handshake write ports.
interface rom_dl_sched_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req;
  logic        port2_ack;
  logic [22:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  port1_ack, port2_ack,
    output ioctl_wait,
    output port1_req, port1_a, port1_ds, port1_d,
    output port2_req, port2_a, port2_ds, port2_d
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output port1_ack, port2_ack,
    input  ioctl_wait,
    input  port1_req, port1_a, port1_ds, port1_d,
    input  port2_req, port2_a, port2_ds, port2_d
  );
endinterface

// File: rtl/rom_dl_fifo.sv
// Small synchronous FIFO of pending download writes; clr restarts the pointers.
module rom_dl_fifo
  import rom_dl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          push,
  input  dl_entry_t     din,
  input  logic          pop,
  output dl_entry_t     dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  dl_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, waddr;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rptr_q];
  // A clear frees every slot, so a same-cycle push always lands in slot 0.
  assign do_push = push & (clr | ~full);
  assign do_pop  = pop & ~empty & ~clr;
  assign waddr   = clr ? '0 : wptr_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[waddr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      wptr_q <= do_push ? AW'(1) : '0;
      rptr_q <= '0;
      cnt_q  <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rom_dl_sched.sv
// ioctl download -> SDRAM port1/port2 write scheduler with FIFO and back-pressure.
// Optional ROM_DL_CHECKSUM_EN adds dl_sum, a 16-bit sum of accepted bytes.
//   state    | meaning
//   ST_IDLE  | nothing outstanding, waiting for a queued byte
//   ST_ISSUE | latch FIFO head onto the ports, pop it, toggle requests
//   ST_WAIT  | waiting for every issued port to acknowledge
module rom_dl_sched
  import rom_dl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] SP_BASE    = SP_BASE_DEF,
  parameter logic [24:0] SP_END     = SP_END_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  rom_dl_sched_if.master    bus,
  output logic              port_we,
  output logic              dl_active,
  output logic              dl_done,
  output logic              dl_err
`ifdef ROM_DL_CHECKSUM_EN
  ,
  output logic [15:0]       dl_sum
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dl_state_e     state_q, state_d;
  logic          wr_q, dl_q, err_q, got_q, iss2_q;
  logic          p1_req_q, p2_req_q;
  logic [22:0]   p1_a_q, p2_a_q;
  logic [1:0]    p1_ds_q, p2_ds_q;
  logic [15:0]   p1_d_q, p2_d_q;
  logic          accept, drop, dl_rise, fifo_clr, pop, full, empty;
  logic          in_sprite, acks_ok;
  logic [CW-1:0] count;
  logic [23:0]   off;
  dl_entry_t     head, push_ent;

  assign dl_rise  = bus.ioctl_download & ~dl_q;
  assign accept   = bus.ioctl_wr & ~wr_q & bus.ioctl_download & (bus.ioctl_index == 8'd0);
  assign fifo_clr = dl_rise & (state_q == ST_IDLE);
  assign drop     = accept & full & ~fifo_clr;
  assign pop      = (state_q == ST_ISSUE);
  assign push_ent = '{addr: bus.ioctl_addr, data: bus.ioctl_dout};

  rom_dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (fifo_clr),
    .push    (accept),
    .din     (push_ent),
    .pop     (pop),
    .dout    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign in_sprite = (head.addr >= SP_BASE) && (head.addr < SP_END);
  assign off       = head.addr[23:0] - SP_BASE[23:0];
  assign acks_ok   = (bus.port1_ack == p1_req_q) && (!iss2_q || (bus.port2_ack == p2_req_q));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!empty && !fifo_clr) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (acks_ok) state_d = empty ? ST_IDLE : ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= 1'b0;
      dl_q  <= 1'b0;
      err_q <= 1'b0;
      got_q <= 1'b0;
    end else begin
      wr_q <= bus.ioctl_wr;
      dl_q <= bus.ioctl_download;
      if (dl_rise) err_q <= 1'b0;
      if (drop)    err_q <= 1'b1;
      if (dl_done) got_q <= 1'b0;
      if (accept)  got_q <= 1'b1;
    end
  end

  // Port outputs only move in ISSUE, so they hold through the whole handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_req_q <= 1'b0;
      p1_a_q   <= '0;
      p1_ds_q  <= 2'b01;
      p1_d_q   <= '0;
      p2_req_q <= 1'b0;
      p2_a_q   <= '0;
      p2_ds_q  <= 2'b01;
      p2_d_q   <= '0;
      iss2_q   <= 1'b0;
    end else if (state_q == ST_ISSUE) begin
      p1_req_q <= ~p1_req_q;
      p1_a_q   <= head.addr[23:1];
      p1_ds_q  <= {head.addr[0], ~head.addr[0]};
      p1_d_q   <= {2{head.data}};
      iss2_q   <= in_sprite;
      if (in_sprite) begin
        p2_req_q <= ~p2_req_q;
        p2_a_q   <= {off[23:16], off[13:0], off[15]};
        p2_ds_q  <= {off[14], ~off[14]};
        p2_d_q   <= {2{head.data}};
      end
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (accept && !drop) begin
      sum_q <= (dl_rise ? 16'd0 : sum_q) + {8'd0, bus.ioctl_dout};
    end else if (dl_rise) begin
      sum_q <= '0;
    end
  end

  assign dl_sum = sum_q;
`endif

  assign bus.ioctl_wait = (count >= CW'(FIFO_DEPTH - 1)) | ((state_q != ST_IDLE) & ~empty);
  assign bus.port1_req  = p1_req_q;
  assign bus.port1_a    = p1_a_q;
  assign bus.port1_ds   = p1_ds_q;
  assign bus.port1_d    = p1_d_q;
  assign bus.port2_req  = p2_req_q;
  assign bus.port2_a    = p2_a_q;
  assign bus.port2_ds   = p2_ds_q;
  assign bus.port2_d    = p2_d_q;

  assign dl_active = bus.ioctl_download | (state_q != ST_IDLE) | ~empty;
  assign port_we   = bus.ioctl_download | dl_active;
  assign dl_done   = got_q & ~bus.ioctl_download & (state_q == ST_IDLE) & empty;
  assign dl_err    = err_q;

endmodule

// File: tb/tb_rom_dl_sched.sv
// Directed bench for rom_dl_sched: latency, region decode, back-pressure, drain, reset.
module tb_rom_dl_sched;

  logic clk = 1'b0;
  logic reset_n;
  logic port_we, dl_active, dl_done, dl_err;
`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] dl_sum;
`endif

  int   checks = 0;
  int   errs   = 0;
  int   done_cnt;
  logic exp_r1 = 1'b0;
  logic exp_r2 = 1'b0;

  always #5 clk = ~clk;

  rom_dl_sched_if bus ();

  rom_dl_sched dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .port_we   (port_we),
    .dl_active (dl_active),
    .dl_done   (dl_done),
    .dl_err    (dl_err)
`ifdef ROM_DL_CHECKSUM_EN
    ,
    .dl_sum    (dl_sum)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    repeat (3) tick();
    bus.ioctl_wr = 1'b0;
    tick();
  endtask

  task automatic ack_all();
    bus.port1_ack = exp_r1;
    bus.port2_ack = exp_r2;
    tick();
    tick();
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.port1_ack      = 1'b0;
    bus.port2_ack      = 1'b0;
    repeat (3) tick();

    chk("rst_p1_req", bus.port1_req, 1'b0);
    chk("rst_p2_req", bus.port2_req, 1'b0);
    chk("rst_p1_ds", bus.port1_ds, 2'b01);
    chk("rst_p2_ds", bus.port2_ds, 2'b01);
    chk("rst_p1_a", bus.port1_a, 23'h0);
    chk("rst_wait", bus.ioctl_wait, 1'b0);
    chk("rst_active", dl_active, 1'b0);
    chk("rst_we", port_we, 1'b0);
    chk("rst_done", dl_done, 1'b0);
    chk("rst_err", dl_err, 1'b0);
    reset_n = 1'b1;
    tick();

    // single port1 write with latency checks
    bus.ioctl_download = 1'b1;
    tick();
    tick();
    chk("dl_active_on", dl_active, 1'b1);
    chk("we_on", port_we, 1'b1);
    bus.ioctl_addr = 25'h00123;
    bus.ioctl_dout = 8'hA5;
    bus.ioctl_wr   = 1'b1;
    tick();
    chk("lat1_req", bus.port1_req, 1'b0);
    tick();
    chk("lat2_req", bus.port1_req, 1'b0);
    chk("lat2_wait", bus.ioctl_wait, 1'b1);
    tick();
    exp_r1 = 1'b1;
    chk("lat3_req", bus.port1_req, exp_r1);
    chk("t1_p2_req", bus.port2_req, exp_r2);
    chk("t1_p1_a", bus.port1_a, 23'h00091);
    chk("t1_p1_ds", bus.port1_ds, 2'b10);
    chk("t1_p1_d", bus.port1_d, 16'hA5A5);
    chk("t1_wait", bus.ioctl_wait, 1'b0);
    bus.ioctl_wr = 1'b0;
    tick();
    tick();
    bus.port1_ack = 1'b1;
    tick();
    tick();
    chk("t1_one_toggle", bus.port1_req, exp_r1);
    chk("t1_p2_quiet", bus.port2_req, exp_r2);

    // sprite dual write; WAIT holds until port2 acks too
    strobe(25'h14001, 8'h3C);
    exp_r1 = ~exp_r1;
    exp_r2 = ~exp_r2;
    chk("t2_p1_req", bus.port1_req, exp_r1);
    chk("t2_p2_req", bus.port2_req, exp_r2);
    chk("t2_p1_a", bus.port1_a, 23'h0A000);
    chk("t2_p2_a", bus.port2_a, 23'h000002);
    chk("t2_p2_ds", bus.port2_ds, 2'b10);
    chk("t2_p2_d", bus.port2_d, 16'h3C3C);
    bus.port1_ack = exp_r1;
    repeat (3) tick();
    strobe(25'h00200, 8'h11);
    chk("t2_hold_req", bus.port1_req, exp_r1);
    chk("t2_hold_a", bus.port1_a, 23'h0A000);
    chk("t2_hold_wait", bus.ioctl_wait, 1'b1);
    bus.port2_ack = exp_r2;
    tick();
    tick();
    exp_r1 = ~exp_r1;
    chk("t2_next_req", bus.port1_req, exp_r1);
    chk("t2_next_a", bus.port1_a, 23'h00100);
    chk("t2_next_d", bus.port1_d, 16'h1111);
    chk("t2_p2_noissue", bus.port2_req, exp_r2);
    ack_all();

    // back-pressure and overflow with port1 ack withheld
    strobe(25'h00300, 8'h40);
    exp_r1 = ~exp_r1;
    strobe(25'h00302, 8'h41);
    chk("t3_wait_q1", bus.ioctl_wait, 1'b1);
    strobe(25'h00304, 8'h42);
    strobe(25'h00306, 8'h43);
    strobe(25'h00308, 8'h44);
    chk("t3_wait_full", bus.ioctl_wait, 1'b1);
    chk("t3_err_before", dl_err, 1'b0);
    strobe(25'h0030A, 8'h45);
    chk("t3_err_set", dl_err, 1'b1);
    chk("t3_head_hold", bus.port1_a, 23'h00180);
    for (int k = 1; k <= 4; k++) begin
      bus.port1_ack = exp_r1;
      tick();
      tick();
      exp_r1 = ~exp_r1;
      chk("t3_ord_req", bus.port1_req, exp_r1);
      chk("t3_ord_a", bus.port1_a, 23'h00180 + k);
      chk("t3_ord_d", bus.port1_d, {2{8'(8'h40 + k)}});
    end
    chk("t3_wait_clear", bus.ioctl_wait, 1'b0);
    ack_all();
    chk("t3_err_sticky", dl_err, 1'b1);

    // drain after the download ends
    strobe(25'h00400, 8'h50);
    exp_r1 = ~exp_r1;
    strobe(25'h00402, 8'h51);
    strobe(25'h00404, 8'h52);
    bus.ioctl_download = 1'b0;
    tick();
    chk("t4_active", dl_active, 1'b1);
    chk("t4_we", port_we, 1'b1);
    chk("t4_no_done", dl_done, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      bus.port1_ack = exp_r1;
      tick();
      tick();
      exp_r1 = ~exp_r1;
      chk("t4_drain_req", bus.port1_req, exp_r1);
      chk("t4_drain_a", bus.port1_a, 23'h00200 + k);
      chk("t4_drain_done", dl_done, 1'b0);
    end
    bus.port1_ack = exp_r1;
    done_cnt = 0;
    repeat (6) begin
      tick();
      if (dl_done) done_cnt++;
    end
    chk("t4_done_once", done_cnt, 1);
    chk("t4_idle_active", dl_active, 1'b0);
    chk("t4_idle_we", port_we, 1'b0);
    chk("t4_err_kept", dl_err, 1'b1);
    bus.ioctl_download = 1'b1;
    tick();
    chk("t4_err_cleared", dl_err, 1'b0);

    // reset in the middle of WAIT
    strobe(25'h00500, 8'h60);
    exp_r1 = ~exp_r1;
    chk("t5_pre_req", bus.port1_req, exp_r1);
    reset_n            = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.port1_ack      = 1'b0;
    bus.port2_ack      = 1'b0;
    #1;
    exp_r1 = 1'b0;
    exp_r2 = 1'b0;
    chk("t5_rst_p1_req", bus.port1_req, 1'b0);
    chk("t5_rst_p1_a", bus.port1_a, 23'h0);
    chk("t5_rst_p1_ds", bus.port1_ds, 2'b01);
    chk("t5_rst_p1_d", bus.port1_d, 16'h0);
    chk("t5_rst_p2_req", bus.port2_req, 1'b0);
    chk("t5_rst_p2_ds", bus.port2_ds, 2'b01);
    chk("t5_rst_active", dl_active, 1'b0);
    chk("t5_rst_wait", bus.ioctl_wait, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    bus.ioctl_download = 1'b1;
    tick();
    strobe(25'h00610, 8'hFF);
    exp_r1 = ~exp_r1;
    chk("t5_req", bus.port1_req, exp_r1);
    chk("t5_a", bus.port1_a, 23'h00308);
    chk("t5_ds", bus.port1_ds, 2'b01);
    chk("t5_d", bus.port1_d, 16'hFFFF);
    ack_all();
    strobe(25'h00611, 8'h02);
    exp_r1 = ~exp_r1;
    chk("t5_req2", bus.port1_req, exp_r1);
    chk("t5_ds2", bus.port1_ds, 2'b10);
    chk("t5_d2", bus.port1_d, 16'h0202);
    ack_all();
`ifdef ROM_DL_CHECKSUM_EN
    chk("sum", dl_sum, 16'h0101);
`endif

    // non-zero index is ignored
    bus.ioctl_index = 8'd1;
    strobe(25'h00700, 8'h99);
    chk("idx_no_req", bus.port1_req, exp_r1);
    chk("idx_no_wait", bus.ioctl_wait, 1'b0);
    bus.ioctl_index = 8'd0;

    // region boundaries
    strobe(25'h1C000, 8'h5A);
    exp_r1 = ~exp_r1;
    chk("end_p1_req", bus.port1_req, exp_r1);
    chk("end_p2_req", bus.port2_req, exp_r2);
    chk("end_p1_a", bus.port1_a, 23'h0E000);
    ack_all();
    strobe(25'h10000, 8'h33);
    exp_r1 = ~exp_r1;
    exp_r2 = ~exp_r2;
    chk("base_p1_req", bus.port1_req, exp_r1);
    chk("base_p2_req", bus.port2_req, exp_r2);
    chk("base_p2_a", bus.port2_a, 23'h0);
    chk("base_p2_ds", bus.port2_ds, 2'b01);
    chk("base_p2_d", bus.port2_d, 16'h3333);
    ack_all();

    bus.ioctl_download = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
